// File: rtl/reg_file_2r1w_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w_pkg
// Description : Shared constants for the single-cycle MIPS register file.
//               - Default data and address widths.
//               - Register count.
//               - Architectural register numbers. R_RA is also used by the
//                 JAL input of the destination-select mux.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_2r1w_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;
    localparam int NUM_REGS       = 32;

    // Architectural register numbers.
    localparam int R_ZERO = 0;
    localparam int R_SP   = 29;
    localparam int R_RA   = 31;

endpackage : reg_file_2r1w_pkg
`default_nettype wire

// File: rtl/reg_file_2r1w_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational read port of the register file.
//               - Decodes the register number into the storage array.
//               - Forces register 0 to read as zero.
//               - When REGFILE_BYPASS_EN is defined, it also forwards the
//                 write data that is being written to the same register in
//                 the current cycle.
// Ports       : i_regs    - storage entries 1..DEPTH-1 (no entry 0)
//               i_rn      - read register number
//               i_byp_we  - qualified write enable (REGFILE_BYPASS_EN only)
//               i_byp_wn  - write register number  (REGFILE_BYPASS_EN only)
//               i_byp_d   - write data             (REGFILE_BYPASS_EN only)
//               o_q       - read data
// Macros      : REGFILE_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import reg_file_2r1w_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEFAULT,
    parameter  int ADDR_W = ADDR_W_DEFAULT,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic [DEPTH-1:1][DATA_W-1:0] i_regs,
    input  logic [ADDR_W-1:0]            i_rn,
`ifdef REGFILE_BYPASS_EN
    input  logic                         i_byp_we,
    input  logic [ADDR_W-1:0]            i_byp_wn,
    input  logic [DATA_W-1:0]            i_byp_d,
`endif
    output logic [DATA_W-1:0]            o_q
);

    logic [DATA_W-1:0] w_q;

    always_comb begin
        // Register 0 has no storage. It keeps this default zero because the
        // loop only matches register numbers 1 and up.
        w_q = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (i_rn == ADDR_W'(i)) begin
                w_q = i_regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Forward a write to this register in the same cycle. The caller
        // has already qualified i_byp_we with reset. A write to register 0
        // is never forwarded.
        if (i_byp_we && (i_byp_wn != ADDR_W'(R_ZERO)) && (i_byp_wn == i_rn)) begin
            w_q = i_byp_d;
        end
`endif
    end

    assign o_q = w_q;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : General-purpose register file for the single-cycle MIPS
//               datapath.
//               - Two combinational read ports (rs and rt).
//               - One synchronous write port.
//               - One combinational debug read port.
//               - Register 0 is hardwired to zero.
// Ports       : CLK   - clock, rising-edge active
//               RST   - synchronous active-high reset, clears every register
//               WE    - write enable (RegWrite)
//               WN    - write register number (destination-select mux)
//               D     - write data (write-back mux)
//               RNA   - read register number, port A (rs)
//               RNB   - read register number, port B (rt)
//               QA    - read data, port A
//               QB    - read data, port B
//               DBG_N - debug read register number
//               DBG_Q - debug read data (never bypassed)
// Macros      : REGFILE_BYPASS_EN - forward same-cycle write data to QA/QB
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WN,
    input  logic [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] RNA,
    input  logic [ADDR_W-1:0] RNB,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB,
    input  logic [ADDR_W-1:0] DBG_N,
    output logic [DATA_W-1:0] DBG_Q
);

    localparam int c_depth = 2 ** ADDR_W;

    // Entries 1..c_depth-1 only. Register 0 is synthesised in the read ports.
    logic [c_depth-1:1][DATA_W-1:0] r_regs;

    // Reset takes priority over a write in the same cycle. A write to
    // register 0 matches no entry, so it is dropped without a special case.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_regs <= '0;
        end else if (WE) begin
            for (int i = 1; i < c_depth; i++) begin
                if (WN == ADDR_W'(i)) begin
                    r_regs[i] <= D;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward only a write that will actually commit on the next edge.
    logic w_byp_we;
    assign w_byp_we = WE & ~RST;
`endif

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .i_regs   (r_regs),
        .i_rn     (RNA),
`ifdef REGFILE_BYPASS_EN
        .i_byp_we (w_byp_we),
        .i_byp_wn (WN),
        .i_byp_d  (D),
`endif
        .o_q      (QA)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .i_regs   (r_regs),
        .i_rn     (RNB),
`ifdef REGFILE_BYPASS_EN
        .i_byp_we (w_byp_we),
        .i_byp_wn (WN),
        .i_byp_d  (D),
`endif
        .o_q      (QB)
    );

    // The debug port always shows the committed register contents.
    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_dbg (
        .i_regs   (r_regs),
        .i_rn     (DBG_N),
`ifdef REGFILE_BYPASS_EN
        .i_byp_we (1'b0),
        .i_byp_wn ('0),
        .i_byp_d  ('0),
`endif
        .o_q      (DBG_Q)
    );

endmodule : reg_file_2r1w
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Self-checking bench for reg_file_2r1w.
//               - Directed scenarios first, then randomized traffic.
//               - Expected values come from an array model of the 32
//                 registers.
// Macros      : REGFILE_BYPASS_EN - selects the expected read-during-write
//                                   behaviour
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WE;
    logic [4:0]  WN;
    logic [31:0] D;
    logic [4:0]  RNA;
    logic [4:0]  RNB;
    logic [31:0] QA;
    logic [31:0] QB;
    logic [4:0]  DBG_N;
    logic [31:0] DBG_Q;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view: 32 registers, entry 0 always reads zero.
    logic [31:0] model [32];

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .WE    (WE),
        .WN    (WN),
        .D     (D),
        .RNA   (RNA),
        .RNB   (RNB),
        .QA    (QA),
        .QB    (QB),
        .DBG_N (DBG_N),
        .DBG_Q (DBG_Q)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value. A data port may see same-cycle forwarding;
    // the debug port never does.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit data_port);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (data_port && WE && !RST && WN == a) return D;
`else
        if (data_port) return model[a];
`endif
        return model[a];
    endfunction

    // Let the inputs settle, then compare all three ports.
    task automatic chk_ports(input string tag);
        #1;
        chk({tag, "_qa"},  QA,    exp_rd(RNA, 1'b1));
        chk({tag, "_qb"},  QB,    exp_rd(RNB, 1'b1));
        chk({tag, "_dbg"}, DBG_Q, exp_rd(DBG_N, 1'b0));
    endtask

    // Clock one edge, update the model, and move 1 time unit past the edge.
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (WE && WN != 5'd0) begin
            model[WN] = D;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] n, input logic [31:0] d);
        WE = 1'b1; WN = n; D = d;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; WN = '0; D = '0;
        RNA = '0; RNB = '0; DBG_N = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;

        // 1: reset, then sweep every address on all three ports.
        tick();
        RST = 1'b0;
        for (int a = 0; a < 32; a++) begin
            RNA = 5'(a); RNB = 5'(31 - a); DBG_N = 5'(a);
            #1;
            chk("reset_qa", QA, 32'h0);
            chk("reset_qb", QB, 32'h0);
            chk("reset_dbg", DBG_Q, 32'h0);
        end

        // 2: basic write and read.
        wr(5'd5, 32'hDEADBEEF);
        RNA = 5'd5; RNB = 5'd5; DBG_N = 5'd5;
        #1;
        chk("wr5_qa", QA, 32'hDEADBEEF);
        chk("wr5_qb", QB, 32'hDEADBEEF);
        chk("wr5_dbg", DBG_Q, 32'hDEADBEEF);

        // 3: a write to register 0 is ignored; the JAL link write to 31 sticks.
        wr(5'd0, 32'hFFFFFFFF);
        RNA = 5'd0; DBG_N = 5'd0;
        #1;
        chk("zero_qa", QA, 32'h0);
        chk("zero_dbg", DBG_Q, 32'h0);
        wr(5'd31, 32'h00400008);
        RNA = 5'd31; RNB = 5'd31;
        #1;
        chk("ra_qa", QA, 32'h00400008);
        chk("ra_qb", QB, 32'h00400008);

        // 4: WE=0 leaves the registers unchanged.
        WE = 1'b0; WN = 5'd7; D = 32'h12345678;
        tick();
        RNA = 5'd7; DBG_N = 5'd7;
        #1;
        chk("we0_qa", QA, 32'h0);
        chk("we0_dbg", DBG_Q, 32'h0);

        // 5: read during write to the same register.
        wr(5'd9, 32'h11111111);
        WE = 1'b1; WN = 5'd9; D = 32'h22222222;
        RNA = 5'd9; RNB = 5'd9; DBG_N = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_qa_pre", QA, 32'h22222222);
        chk("rdw_qb_pre", QB, 32'h22222222);
`else
        chk("rdw_qa_pre", QA, 32'h11111111);
        chk("rdw_qb_pre", QB, 32'h11111111);
`endif
        chk("rdw_dbg_pre", DBG_Q, 32'h11111111);
        tick();
        WE = 1'b0;
        #1;
        chk("rdw_qa_post", QA, 32'h22222222);
        chk("rdw_dbg_post", DBG_Q, 32'h22222222);

        // 6: reset wins over a write in the same cycle.
        wr(5'd3, 32'hA5A5A5A5);
        RST = 1'b1; WE = 1'b1; WN = 5'd4; D = 32'h5;
        RNA = 5'd4; RNB = 5'd3;
        chk_ports("rstpri_pre");
        tick();
        RST = 1'b0; WE = 1'b0;
        RNA = 5'd3; RNB = 5'd4; DBG_N = 5'd9;
        #1;
        chk("rstpri_r3", QA, 32'h0);
        chk("rstpri_r4", QB, 32'h0);
        chk("rstpri_r9", DBG_Q, 32'h0);

        // Randomized traffic checked against the model before each edge.
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 63) == 0);
            WE  = $urandom_range(0, 3) != 0;
            WN  = 5'($urandom_range(0, 31));
            D   = $urandom;
            RNA = ($urandom_range(0, 3) == 0) ? WN : 5'($urandom_range(0, 31));
            RNB = ($urandom_range(0, 3) == 0) ? WN : 5'($urandom_range(0, 31));
            DBG_N = ($urandom_range(0, 3) == 0) ? WN : 5'($urandom_range(0, 31));
            chk_ports("rand");
            tick();
        end

        RST = 1'b0; WE = 1'b0;
        for (int a = 0; a < 32; a++) begin
            RNA = 5'(a); RNB = 5'(a); DBG_N = 5'(31 - a);
            chk_ports("final");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_2r1w
`default_nettype wire
